// File: rtl/fechadura_pkg.sv
// Shared types and helpers for the multi-user lock controller.
package fechadura_pkg;

  typedef enum logic [2:0] {
    TRAVADO,
    VERIFICA,
    DESTRAVADO,
    PORTA_ABERTA,
    SETUP,
    BLOQUEIO,
    TRAVA_INTERNA
  } estado_t;

  localparam logic [3:0] NIBBLE_BLANK = 4'hF;

  // Factory master code 1,2,3,4; the first digit sits in the low nibble.
  localparam logic [15:0] MASTER_DEFAULT = 16'h4321;

  // Double-dabble conversion of 0..999 into three BCD digits.
  function automatic logic [11:0] bin2bcd(input logic [9:0] bin);
    logic [21:0] s;
    s = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      if (s[13:10] >= 4'd5) s[13:10] = s[13:10] + 4'd3;
      if (s[17:14] >= 4'd5) s[17:14] = s[17:14] + 4'd3;
      if (s[21:18] >= 4'd5) s[21:18] = s[21:18] + 4'd3;
      s = s << 1;
    end
    return s[21:10];
  endfunction

endpackage

// File: rtl/temporizador_seg.sv
// Seconds timer: down-counting prescaler plus a seconds down-counter.
// A load restarts the prescaler, so N seconds end exactly N*TICKS_SEG cycles later.
module temporizador_seg #(
  parameter int TICKS_SEG = 1000,
  parameter int W         = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_valor,
  output logic         o_tick,
  output logic         o_zero,
  output logic [W-1:0] o_seg,
  output logic [W-1:0] o_seg_prox
);

  localparam int PW = (TICKS_SEG > 1) ? $clog2(TICKS_SEG) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICKS_SEG - 1);

  logic [PW-1:0] r_presc;
  logic [W-1:0]  r_seg;
  logic [W-1:0]  w_seg_prox;

  assign o_tick     = (r_presc == '0);
  assign o_zero     = (r_seg == '0);
  assign o_seg      = r_seg;
  assign o_seg_prox = w_seg_prox;

  // Next seconds value: load wins, otherwise count down on tick and hold at zero.
  always_comb begin
    w_seg_prox = r_seg;
    if (i_load)
      w_seg_prox = i_valor;
    else if (o_tick && !o_zero)
      w_seg_prox = r_seg - W'(1);
  end

  // Prescaler and seconds registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= PRESC_TOP;
      r_seg   <= '0;
    end else begin
      r_seg <= w_seg_prox;
      if (i_load || o_tick)
        r_presc <= PRESC_TOP;
      else
        r_presc <= r_presc - PW'(1);
    end
  end

endmodule

// File: rtl/operacional_multi.sv
// Operational controller of the multi-user keypad lock.
//
// state         | meaning
// TRAVADO       | locked, waiting for entry or buttons
// VERIFICA      | one cycle comparing latched entry with all slots
// DESTRAVADO    | unlocked, door still closed, auto-relock timer running
// PORTA_ABERTA  | door open, beep after T_BIP seconds
// SETUP         | door open, password slots writable
// BLOQUEIO      | lockout after too many wrong entries, countdown shown
// TRAVA_INTERNA | locked from inside, keypad and display off
module operacional_multi
  import fechadura_pkg::*;
#(
  parameter int TICKS_SEG   = 1000,
  parameter int N_USERS     = 4,
  parameter int N_DIG       = 8,
  parameter int MAX_TENT    = 3,
  parameter int T_BLOQ_BASE = 30,
  parameter int T_TRAVA     = 5,
  parameter int T_BIP       = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sensor_contato,
  input  logic                       botao_interno,
  input  logic                       botao_bloqueio,
  input  logic                       botao_config,
  input  logic [4*N_DIG-1:0]         digitos_value,
  input  logic                       digitos_valid,
  input  logic [$clog2(N_USERS)-1:0] setup_slot,
  input  logic [4*N_DIG-1:0]         setup_senha,
  input  logic                       setup_we,
  input  logic                       setup_ok,
  output logic [11:0]                bcd_out,
  output logic                       teclado_en,
  output logic                       display_en,
  output logic                       setup_on,
  output logic                       tranca,
  output logic                       bip,
  output logic                       bloqueado,
  output logic [$clog2(N_USERS)-1:0] user_id
);

  localparam int DW = 4 * N_DIG;
  localparam int UW = $clog2(N_USERS);
  localparam int EW = $clog2(MAX_TENT + 1);
  localparam int TW = 10;
  localparam logic [DW-1:0] BLANK       = {N_DIG{NIBBLE_BLANK}};
  localparam logic [DW-1:0] MASTER_INIT = (BLANK << 16) | DW'(MASTER_DEFAULT);
  localparam logic [EW-1:0] ERR_LIM     = EW'(MAX_TENT - 1);

  estado_t       r_estado, w_prox;
  logic [DW-1:0] r_slot [N_USERS];
  logic [DW-1:0] r_entrada;
  logic [EW-1:0] r_err;
  logic [1:0]    r_nbloq;
  logic [UW-1:0] r_user, w_idx;
  logic          w_match, w_load, w_tick, w_zero;
  logic [TW-1:0] w_valor, w_seg, w_seg_prox;

  // Parallel compare against every enabled slot; lowest index wins.
  always_comb begin
    w_match = 1'b0;
    w_idx   = '0;
    for (int i = N_USERS - 1; i >= 0; i--) begin
      if (r_slot[i] != BLANK && r_slot[i] == r_entrada) begin
        w_match = 1'b1;
        w_idx   = UW'(i);
      end
    end
  end

  // Next-state decode.
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      TRAVADO: begin
        if (botao_interno)                           w_prox = DESTRAVADO;
        else if (digitos_valid && digitos_value != BLANK) w_prox = VERIFICA;
        else if (botao_bloqueio)                     w_prox = TRAVA_INTERNA;
      end
      VERIFICA: begin
        if (w_match)               w_prox = DESTRAVADO;
        else if (r_err >= ERR_LIM) w_prox = BLOQUEIO;
        else                       w_prox = TRAVADO;
      end
      DESTRAVADO: begin
        if (!sensor_contato)                 w_prox = PORTA_ABERTA;
        else if (w_tick && w_seg <= TW'(1))  w_prox = TRAVADO;
      end
      PORTA_ABERTA: begin
        if (sensor_contato)    w_prox = TRAVADO;
        else if (botao_config) w_prox = SETUP;
      end
      SETUP: begin
        if (setup_ok) w_prox = PORTA_ABERTA;
      end
      BLOQUEIO: begin
        if (botao_interno) w_prox = DESTRAVADO;
        else if (w_zero)   w_prox = TRAVADO;
      end
      TRAVA_INTERNA: begin
        if (botao_interno)       w_prox = DESTRAVADO;
        else if (botao_bloqueio) w_prox = TRAVADO;
      end
      default: w_prox = TRAVADO;
    endcase
  end

  // Timer preload for the state being entered; lockout doubles up to x8.
  always_comb begin
    w_valor = '0;
    case (w_prox)
      DESTRAVADO:   w_valor = TW'(T_TRAVA);
      PORTA_ABERTA: w_valor = TW'(T_BIP);
      BLOQUEIO:     w_valor = TW'(T_BLOQ_BASE) << r_nbloq;
      default:      w_valor = '0;
    endcase
  end

  assign w_load = (w_prox != r_estado);

  temporizador_seg #(
    .TICKS_SEG (TICKS_SEG),
    .W         (TW)
  ) u_temporizador (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_valor    (w_valor),
    .o_tick     (w_tick),
    .o_zero     (w_zero),
    .o_seg      (w_seg),
    .o_seg_prox (w_seg_prox)
  );

  // State register, entry latch, error and lockout counters, last user.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_estado  <= TRAVADO;
      r_entrada <= BLANK;
      r_err     <= '0;
      r_nbloq   <= '0;
      r_user    <= '0;
    end else begin
      r_estado <= w_prox;
      if (r_estado == TRAVADO && w_prox == VERIFICA)
        r_entrada <= digitos_value;
      if (r_estado == VERIFICA) begin
        if (w_match) begin
          r_user  <= w_idx;
          r_err   <= '0;
          r_nbloq <= '0;
        end else if (r_err >= ERR_LIM) begin
          r_err <= '0;
          if (r_nbloq != 2'd3)
            r_nbloq <= r_nbloq + 2'd1;
        end else begin
          r_err <= r_err + EW'(1);
        end
      end
    end
  end

  // Password slots; blanking the master slot is refused so it can't be lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_USERS; i++)
        r_slot[i] <= (i == 0) ? MASTER_INIT : BLANK;
    end else if (r_estado == SETUP && setup_we &&
                 !(setup_slot == '0 && setup_senha == BLANK)) begin
      r_slot[setup_slot] <= setup_senha;
    end
  end

  // Outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tranca     <= 1'b1;
      bip        <= 1'b0;
      teclado_en <= 1'b1;
      display_en <= 1'b1;
      setup_on   <= 1'b0;
      bloqueado  <= 1'b0;
      bcd_out    <= 12'hFFF;
    end else begin
      tranca     <= !(w_prox inside {DESTRAVADO, PORTA_ABERTA, SETUP});
      bip        <= (w_prox == PORTA_ABERTA) && (w_seg_prox == '0);
      teclado_en <= !(w_prox inside {SETUP, BLOQUEIO, TRAVA_INTERNA});
      display_en <= (w_prox != TRAVA_INTERNA);
      setup_on   <= (w_prox == SETUP);
      bloqueado  <= (w_prox == BLOQUEIO);
      bcd_out    <= (w_prox == BLOQUEIO) ? bin2bcd(w_seg_prox) : 12'hFFF;
    end
  end

  assign user_id = r_user;

endmodule
